// File: rtl/stream_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_n
// Brief    : Registered 1-to-2 valid/ready demux with a 2-entry FIFO and a
//            delivered-word counter per output port.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_n #(
  parameter int n  = 32,
  parameter int cw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [n-1:0]  a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [n-1:0]  b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [cw-1:0] a_count,
  output logic [cw-1:0] b_count
);

  // Port index 0 is A (in_sel=1), index 1 is B (in_sel=0).
  logic [1:0]    w_space;
  logic [1:0]    w_valid;
  logic [1:0]    w_push;
  logic [1:0]    w_pop;
  logic [1:0]    w_xready;
  logic [n-1:0]  w_head [2];
  logic [cw-1:0] w_cnt  [2];

  assign w_xready = {b_ready, a_ready};

  // Acceptance looks only at the selected FIFO's registered occupancy.
  assign in_ready  = in_sel ? w_space[0] : w_space[1];
  assign w_push[0] = in_valid &  in_sel & w_space[0];
  assign w_push[1] = in_valid & ~in_sel & w_space[1];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [n-1:0]  r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_occ;
    logic [cw-1:0] r_count;

    assign w_space[p] = (r_occ != 2'd2);
    assign w_valid[p] = (r_occ != 2'd0);
    assign w_pop[p]   = w_valid[p] & w_xready[p];
    assign w_head[p]  = r_mem[r_rptr];
    assign w_cnt[p]   = r_count;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wptr   <= 1'b0;
        r_rptr   <= 1'b0;
        r_occ    <= 2'd0;
        r_count  <= '0;
      end else begin
        if (w_push[p]) begin
          r_mem[r_wptr] <= in_data;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop[p]) begin
          r_rptr  <= ~r_rptr;
          r_count <= r_count + 1'b1;
        end
        // Push and pop together leave occupancy unchanged.
        case ({w_push[p], w_pop[p]})
          2'b10:   r_occ <= r_occ + 2'd1;
          2'b01:   r_occ <= r_occ - 2'd1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign a_data  = w_head[0];
  assign b_data  = w_head[1];
  assign a_valid = w_valid[0];
  assign b_valid = w_valid[1];
  assign a_count = w_cnt[0];
  assign b_count = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_n
// Brief    : Directed self-checking bench for stream_demux_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_n;

  localparam int N  = 32;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [N-1:0]  b_data;
  logic          b_valid;
  logic          b_ready;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;

  stream_demux_n #(.n(N), .cw(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [N-1:0] d);
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Reset pulse placed between edges.
  task automatic pulse_reset();
    #3 rst = 1'b1;
    #3 rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    #12;
    // Reset state
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    in_sel = 1'b1; #1 chk("rst_in_ready_a", in_ready, 1);
    in_sel = 1'b0; #1 chk("rst_in_ready_b", in_ready, 1);
    rst = 1'b0;
    tick();

    // Single word to A
    a_ready = 1'b1;
    in_sel = 1'b1; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    #1 chk("single_in_ready", in_ready, 1);
    chk("single_no_passthru", a_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("single_a_valid", a_valid, 1);
    chk("single_a_data", a_data, 32'hDEADBEEF);
    chk("single_b_valid", b_valid, 0);
    chk("single_a_count0", a_count, 0);
    tick();
    chk("single_a_empty", a_valid, 0);
    chk("single_a_count1", a_count, 1);
    chk("single_b_valid2", b_valid, 0);

    // Stall fill on B, A still accepts
    a_ready = 1'b0; b_ready = 1'b0;
    push(1'b0, 32'h11);
    push(1'b0, 32'h22);
    in_sel = 1'b0; in_data = 32'h44; in_valid = 1'b1;
    #1 chk("stall_b_blocked", in_ready, 0);
    in_sel = 1'b1; in_data = 32'h33;
    #1 chk("stall_a_open", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("stall_a_valid", a_valid, 1);
    chk("stall_a_data", a_data, 32'h33);
    chk("stall_b_head", b_data, 32'h11);
    b_ready = 1'b1;
    tick();
    chk("stall_b_second", b_data, 32'h22);
    chk("stall_b_count1", b_count, 1);
    tick();
    chk("stall_b_empty", b_valid, 0);
    chk("stall_b_count2", b_count, 2);
    a_ready = 1'b1;
    tick();
    chk("stall_a_count", a_count, 2);
    chk("stall_a_empty", a_valid, 0);

    // Simultaneous push/pop at occupancy 1 on A
    a_ready = 1'b0;
    push(1'b1, 32'h5);
    chk("pp_a_head5", a_data, 32'h5);
    a_ready = 1'b1;
    in_sel = 1'b1; in_data = 32'h6; in_valid = 1'b1;
    #1 chk("pp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("pp_a_valid", a_valid, 1);
    chk("pp_a_data6", a_data, 32'h6);
    chk("pp_a_count3", a_count, 3);
    tick();
    chk("pp_a_empty", a_valid, 0);
    chk("pp_a_count4", a_count, 4);

    // Async reset mid-operation with both FIFOs full
    a_ready = 1'b0; b_ready = 1'b0;
    push(1'b1, 32'hA1);
    push(1'b1, 32'hA2);
    push(1'b0, 32'hB1);
    push(1'b0, 32'hB2);
    chk("full_a_valid", a_valid, 1);
    chk("full_b_valid", b_valid, 1);
    in_sel = 1'b1; #1 chk("full_a_blocked", in_ready, 0);
    in_sel = 1'b0; #1 chk("full_b_blocked", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_a_valid", a_valid, 0);
    chk("arst_b_valid", b_valid, 0);
    chk("arst_a_count", a_count, 0);
    chk("arst_b_count", b_count, 0);
    chk("arst_a_data", a_data, 0);
    chk("arst_in_ready_b", in_ready, 1);
    in_sel = 1'b1; #1 chk("arst_in_ready_a", in_ready, 1);
    rst = 1'b0;
    tick();

    // Streaming 100 words, alternating A then B
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_sel = (i % 2 == 0); in_data = 32'(i); in_valid = 1'b1;
      #1;
      if (in_ready !== 1'b1) chk("stream_in_ready", in_ready, 1);
      tick();
      if (i % 2 == 0) begin
        if (a_data !== 32'(i) || a_valid !== 1'b1) chk("stream_a_data", a_data, 32'(i));
      end else begin
        if (b_data !== 32'(i) || b_valid !== 1'b1) chk("stream_b_data", b_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_a_count", a_count, 50);
    chk("stream_b_count", b_count, 50);

    // Counter wrap on B
    pulse_reset();
    b_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_sel = 1'b0; in_data = 32'(i + 1000); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_b_count255", b_count, 255);
    chk("wrap_b_last", b_data, 32'(255 + 1000));
    tick();
    chk("wrap_b_count0", b_count, 0);
    chk("wrap_b_empty", b_valid, 0);
    chk("wrap_a_count", a_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
